fifo_stream_reader: RTL and testbench

//  Read-side drain engine for the 8x8 synchronous FIFO. Issues rd pulses into the FIFO

---
 rtl/fifo_stream_reader_if.sv | 10 +
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 tb/tb_fifo_stream_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready byte stream leaving the FIFO read-side drain engine.
// The master drives data/valid and the slave returns ready.
interface fifo_stream_reader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains the 8x8 synchronous FIFO into a 2-entry buffer and presents it as a valid/ready stream.
// Optional level-triggered bursts are enabled with the FIFO_RD_THRESH_EN macro.
module fifo_stream_reader #(
  parameter int START_LEVEL = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             fifo_rd,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  input  logic [3:0]       fifo_cnt,
  input  logic             flush,
  fifo_stream_reader_if.master strm,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e           state_q;
  logic [1:0]       occ_q, occ_d;
  logic             pend_q;
  logic [7:0]       head_q, head_d;
  logic [7:0]       tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;
  logic [1:0]       level;
  logic [1:0]       occAfterPop;
  logic             start;
  logic             en;
  logic             hold;

  assign pop         = (occ_q != 2'd0) && strm.m_ready;
  assign occAfterPop = occ_q - 2'(pop);
  // Occupancy the buffer will have after this edge; occ+pend never exceeds 2.
  assign level       = occAfterPop + 2'(pend_q);

`ifdef FIFO_RD_THRESH_EN
  assign start = (int'(fifo_cnt) >= START_LEVEL) || flush;
  assign en    = (state_q == DRAIN);
  assign hold  = flush;
`else
  logic unused_cfg;
  assign start      = 1'b1;
  assign en         = 1'b1;
  assign hold       = 1'b0;
  assign unused_cfg = ^{flush, fifo_cnt, (START_LEVEL > 0)};
`endif

  assign fifo_rd = reset && en && !fifo_empty && (level < 2'd2);

  // Head shifts on pop; a pending byte lands in the first free slot after that shift.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    if (pend_q) begin
      if (occAfterPop == 2'd0) begin
        head_d = fifo_dout;
      end else begin
        tail_d = fifo_dout;
      end
    end
    occ_d = level;
    cnt_d = cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q  <= 2'd0;
      pend_q <= 1'b0;
      head_q <= 8'h00;
      tail_q <= 8'h00;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= fifo_rd;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= DRAIN;
        DRAIN:   if (fifo_empty && (occ_q == 2'd0) && !pend_q && !hold) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strm.m_data  = head_q;
  assign strm.m_valid = (occ_q != 2'd0);
  assign rd_count     = cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural 8x8 FIFO on its read port.
// Threshold scenarios are compiled in when FIFO_RD_THRESH_EN is defined.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifoRd;
  logic [7:0]  fifoDout = 8'h00;
  logic        fifoEmpty = 1'b1;
  logic [3:0]  fifoCnt = 4'd0;
  logic        flush;
  logic [15:0] rdCount;

  logic        wrEn;
  logic [7:0]  wrData;
  logic [7:0]  fifoQ[$];
  logic [7:0]  expQ[$];
  int          outst = 0;

  int          compared = 0;
  int          mismatched = 0;
  int          popsSeen = 0;
  logic        bpMode = 1'b0;
  int          patIdx = 0;
  logic        prevStall = 1'b0;
  logic [7:0]  prevData = 8'h00;
  logic        pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  fifo_stream_reader_if sIf();

  fifo_stream_reader #(.START_LEVEL(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_rd   (fifoRd),
    .fifo_dout (fifoDout),
    .fifo_empty(fifoEmpty),
    .fifo_cnt  (fifoCnt),
    .flush     (flush),
    .strm      (sIf),
    .rd_count  (rdCount)
  );

  // Registered-output FIFO model; also tracks bytes fetched but not yet delivered.
  always @(posedge clk) begin
    if (fifoRd && fifoQ.size() > 0) fifoDout <= fifoQ.pop_front();
    if (wrEn && fifoQ.size() < 8) fifoQ.push_back(wrData);
    fifoCnt   <= 4'(fifoQ.size());
    fifoEmpty <= (fifoQ.size() == 0);
    if (!reset) outst <= 0;
    else outst <= outst + (fifoRd ? 1 : 0) - ((sIf.m_valid && sIf.m_ready) ? 1 : 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bpMode) begin
        checkOutput("occ_bound", 32'(outst <= 2), 32'd1);
        if (prevStall) begin
          checkOutput("stall_valid", 32'(sIf.m_valid), 32'd1);
          checkOutput("stall_data", 32'(sIf.m_data), 32'(prevData));
        end
      end
      if (sIf.m_valid && sIf.m_ready) begin
        popsSeen++;
        if (expQ.size() == 0) checkOutput("unexpected_byte", 32'(sIf.m_data), 32'hFFFF_FFFF);
        else checkOutput("stream_data", 32'(sIf.m_data), 32'(expQ.pop_front()));
      end
      prevStall = sIf.m_valid && !sIf.m_ready;
      prevData  = sIf.m_data;
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (bpMode) begin
      sIf.m_ready = pat[patIdx % 6];
      patIdx++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    wrEn   = 1'b1;
    wrData = b;
    expQ.push_back(b);
    stepCycle();
    wrEn   = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    expQ.delete();
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int c = 0; c < budget && expQ.size() != 0; c++) stepCycle();
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int base;
    int remaining;
    int rdHigh, validHigh, firstRd, firstValid;
    reset = 1'b0; flush = 1'b0; wrEn = 1'b0; wrData = 8'h00; sIf.m_ready = 1'b1;

    // Reset held while the FIFO fills up.
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("rst_fifo_rd", 32'(fifoRd), 32'd0);
    checkOutput("rst_m_valid", 32'(sIf.m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(sIf.m_data), 32'h00);
    checkOutput("rst_rd_count", 32'(rdCount), 32'd0);

    // Burst of the 8 bytes after release, no gaps.
    reset = 1'b1;
    for (int c = 0; c < 20 && !sIf.m_valid; c++) stepCycle();
    for (int k = 0; k < 8; k++) begin
      checkOutput("burst_valid", 32'(sIf.m_valid), 32'd1);
      stepCycle();
    end
    checkOutput("burst_end_valid", 32'(sIf.m_valid), 32'd0);
    checkOutput("burst_rd_count", 32'(rdCount), 32'd8);
    checkOutput("burst_fifo_empty", 32'(fifoEmpty), 32'd1);
    checkOutput("burst_scoreboard", 32'(expQ.size()), 32'd0);

`ifndef FIFO_RD_THRESH_EN
    // Single byte: one read, one valid cycle two clocks later.
    doReset();
    applyStimulus(8'hA5);
    rdHigh = 0; validHigh = 0; firstRd = -1; firstValid = -1;
    for (int c = 0; c < 8; c++) begin
      if (fifoRd) begin rdHigh++; if (firstRd < 0) firstRd = c; end
      if (sIf.m_valid) begin validHigh++; if (firstValid < 0) firstValid = c; end
      stepCycle();
    end
    checkOutput("single_rd_cycles", 32'(rdHigh), 32'd1);
    checkOutput("single_valid_cycles", 32'(validHigh), 32'd1);
    checkOutput("single_latency", 32'(firstValid - firstRd), 32'd2);
    checkOutput("single_rd_count", 32'(rdCount), 32'd1);
`endif

    // Backpressure with ready pattern 1,0,0,1,0,1 repeating.
    doReset();
    bpMode = 1'b1; patIdx = 0;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    waitDrain("bp_drain", 100);
    checkOutput("bp_rd_count", 32'(rdCount), 32'd8);
    bpMode = 1'b0; sIf.m_ready = 1'b1;

`ifdef FIFO_RD_THRESH_EN
    // Below threshold nothing is read; the fourth byte starts the burst.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(8'h30 + 8'(i));
    rdHigh = 0;
    for (int c = 0; c < 6; c++) begin if (fifoRd) rdHigh++; stepCycle(); end
    checkOutput("thr_below_rd", 32'(rdHigh), 32'd0);
    applyStimulus(8'h33);
    waitDrain("thr_drain", 40);
    checkOutput("thr_rd_count", 32'(rdCount), 32'd4);
    applyStimulus(8'h5A);
    rdHigh = 0;
    for (int c = 0; c < 4; c++) begin if (fifoRd) rdHigh++; stepCycle(); end
    checkOutput("thr_single_idle", 32'(rdHigh), 32'd0);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    waitDrain("flush_drain", 40);
    checkOutput("flush_rd_count", 32'(rdCount), 32'd5);
`endif

    // Reset after three deliveries; the FIFO remainder must stream afterwards.
    doReset();
    sIf.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) applyStimulus(8'h10 + 8'(i));
    sIf.m_ready = 1'b1;
    base = popsSeen;
    for (int c = 0; c < 20 && (popsSeen - base) < 3; c++) stepCycle();
    reset = 1'b0;
    expQ.delete();
    foreach (fifoQ[i]) expQ.push_back(fifoQ[i]);
    remaining = fifoQ.size();
    checkOutput("mid_remaining", 32'(remaining), 32'd3);
    stepCycle();
    stepCycle();
    checkOutput("mid_rst_valid", 32'(sIf.m_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(sIf.m_data), 32'h00);
    checkOutput("mid_rst_count", 32'(rdCount), 32'd0);
    reset = 1'b1;
`ifdef FIFO_RD_THRESH_EN
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
`endif
    waitDrain("mid_drain", 40);
    checkOutput("mid_rd_count", 32'(rdCount), 32'(remaining));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
